// File: rtl/pwm_adc.sv
// First-order delta-sigma ADC front end: synchronises the comparator bit,
// feeds it back to the RC integrator and counts ones density per window.
module pwm_adc #(
    parameter int RES         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm_in,
    output logic           pwm_out,
    output logic [RES-1:0] adc_data,
    output logic           adc_valid,
    output logic           pwm_mon
);

    localparam logic [RES-1:0] MAX   = '1;
    localparam logic [RES:0]   MAX_W = {1'b0, MAX};

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [RES-1:0]         cnt;
    logic [RES:0]           ones;
    logic [RES:0]           sum;
    logic [RES-1:0]         sat;

    assign s = sync[SYNC_STAGES-1];

    // Window total including the bit sampled on the closing edge, clamped to MAX.
    always_comb begin
        sum = ones + {{RES{1'b0}}, s};
        sat = (sum > MAX_W) ? MAX : sum[RES-1:0];
    end

    // Metastability is confined to this chain; only its last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Delta-sigma feedback bit to the external integrator.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= s;
        end
    end

    // Window counter, ones accumulator and sample publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ones      <= '0;
            adc_data  <= '0;
            adc_valid <= 1'b0;
        end else if (cnt == MAX) begin
            cnt       <= '0;
            ones      <= '0;
            adc_data  <= sat;
            adc_valid <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            ones      <= sum;
            adc_valid <= 1'b0;
        end
    end

    // Monitor PWM regenerated from the sample held at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_mon <= 1'b0;
        end else begin
            pwm_mon <= (cnt < adc_data);
        end
    end

endmodule

// File: tb/tb_pwm_adc.sv
// Scoreboard bench for pwm_adc: randomized comparator streams checked
// against a history-based model of the window density and monitor PWM.
module tb_pwm_adc;

    localparam int RES = 8;
    localparam int N   = 1 << RES;

    logic           clk;
    logic           rst;
    logic           pwm_in;
    logic           pwm_out;
    logic [RES-1:0] adc_data;
    logic           adc_valid;
    logic           pwm_mon;

    pwm_adc #(.RES(RES), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .pwm_out   (pwm_out),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .pwm_mon   (pwm_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             k;
        logic           po;
        logic           pm;
        logic           pv;
        logic [RES-1:0] pd;
    } cyc_t;

    typedef struct {
        int             k;
        logic [RES-1:0] d;
    } smp_t;

    cyc_t cq[$];
    smp_t sq[$];

    int vectors = 0;
    int errors  = 0;

    // Model state: pwm_in sampled at each edge since reset release.
    logic hist[$];
    int   k   = 0;
    int   acc = 0;
    int   dm  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic r);
        cyc_t c;
        smp_t sm;
        int   sbit;
        @(negedge clk);
        pwm_in = v;
        rst    = r;
        @(posedge clk);
        if (r) begin
            k   = 0;
            acc = 0;
            dm  = 0;
            hist.delete();
            c.k  = 0;
            c.po = 1'b0;
            c.pm = 1'b0;
            c.pv = 1'b0;
            c.pd = '0;
        end else begin
            k++;
            hist.push_back(v);
            // bit used at edge k is the input sampled two edges earlier
            sbit = (k >= 3) ? int'(hist[k-3]) : 0;
            c.k  = k;
            c.po = sbit[0];
            c.pm = (((k - 1) % N) < dm);
            acc += sbit;
            if (k % N == 0) begin
                dm   = (acc > N - 1) ? N - 1 : acc;
                acc  = 0;
                sm.k = k;
                sm.d = dm[RES-1:0];
                sq.push_back(sm);
                c.pv = 1'b1;
            end else begin
                c.pv = 1'b0;
            end
            c.pd = dm[RES-1:0];
        end
        cq.push_back(c);
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation.
    cyc_t mc;
    smp_t ms;
    always @(negedge clk) begin
        if (cq.size() > 0) begin
            mc = cq.pop_front();
            chk("pwm_out", int'(pwm_out), int'(mc.po));
            chk("pwm_mon", int'(pwm_mon), int'(mc.pm));
            chk("adc_valid", int'(adc_valid), int'(mc.pv));
            chk("adc_data_held", int'(adc_data), int'(mc.pd));
            if (adc_valid === 1'b1) begin
                if (sq.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    ms = sq.pop_front();
                    chk("sample_edge", mc.k, ms.k);
                    chk("sample_data", int'(adc_data), int'(ms.d));
                end
            end
        end
    end

    task automatic run(input int n, input int mode, input int p);
        logic v;
        v = 1'b0;
        for (int i = 0; i < n; i++) begin
            unique case (mode)
                0: v = 1'b0;
                1: v = 1'b1;
                2: v = ~v;
                default: v = (int'($urandom_range(0, 99)) < p);
            endcase
            step(v, 1'b0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // zeros for three windows
        run(3 * N, 0, 0);
        // ones: saturate at MAX
        step(1'b1, 1'b1);
        run(2 * N, 1, 0);
        // toggling: half density
        step(1'b0, 1'b1);
        run(2 * N, 2, 0);
        // single step: feedback latency
        step(1'b0, 1'b1);
        run(10, 0, 0);
        run(6, 1, 0);
        // reset mid-window at cnt=100
        step(1'b1, 1'b1);
        run(100, 1, 0);
        step(1'b1, 1'b1);
        run(N + 4, 1, 0);
        // random densities over ten windows
        for (int w = 0; w < 10; w++) begin
            run(N, 3, int'($urandom_range(0, 100)));
        end
        @(negedge clk);
        @(negedge clk);
        chk("pending_cycles", cq.size(), 0);
        chk("pending_samples", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
